// File: rtl/sar_pkg.sv
// Shared definitions for the SAR conversion sequencer: sample width,
// averaging constants and the sequencer state type.
package sar_pkg;

    localparam int SAMPLE_W  = 8;
    localparam int AVG_COUNT = 4;
    localparam int AVG_SUM_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_GAP  = 2'd2
    } sar_state_e;

endpackage

// File: rtl/sar_result_fifo.sv
// Result FIFO for the SAR sequencer. Holds DEPTH samples, shows the head
// entry combinationally, and flags a sticky overflow when a sample has to be
// dropped because the FIFO is full and nothing is being popped.
module sar_result_fifo
    import sar_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push_i,
    input  logic [SAMPLE_W-1:0]         push_data_i,
    input  logic                        pop_ready_i,
    input  logic                        clr_flags_i,
    output logic [SAMPLE_W-1:0]         out_data_o,
    output logic                        out_valid_o,
    output logic [$clog2(DEPTH):0]      count_o,
    output logic                        overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [SAMPLE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]       wrPtr_q;
    logic [AW-1:0]       rdPtr_q;
    logic [AW:0]         count_q;
    logic [AW:0]         count_d;
    logic                overflow_q;
    logic                doPop;
    logic                doWrite;
    logic                drop;

    // Decide what happens this cycle: a pop frees a slot, so a push into a
    // full FIFO is only dropped when no pop happens alongside it.
    always_comb begin
        doPop   = (count_q != '0) && pop_ready_i;
        doWrite = push_i && ((count_q != FULL_COUNT) || doPop);
        drop    = push_i && (count_q == FULL_COUNT) && !doPop;
        count_d = count_q;
        if (doWrite && !doPop) begin
            count_d = count_q + 1'b1;
        end else if (doPop && !doWrite) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointers, occupancy and the sticky overflow; a new drop beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (doWrite) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clr_flags_i) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // Sample storage; contents are only meaningful while counted as valid.
    always_ff @(posedge clk) begin
        if (doWrite) begin
            mem_q[wrPtr_q] <= push_data_i;
        end
    end

    assign out_valid_o = (count_q != '0);
    assign out_data_o  = (count_q != '0) ? mem_q[rdPtr_q] : '0;
    assign count_o     = count_q;
    assign overflow_o  = overflow_q;

endmodule

// File: rtl/sar_sequencer.sv
// SAR conversion sequencer: repeatedly requests conversions from a SAR
// controller, captures results into a FIFO and enforces a timeout and an
// idle gap between conversions.
// Optional feature: define SAR_SEQ_AVG_EN to push the average of every four
// successful captures instead of every capture.
module sar_sequencer
    import sar_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic [7:0]                   period,
    output logic                         go,
    input  logic                         conv_valid,
    input  logic [SAMPLE_W-1:0]          conv_result,
    output logic [SAMPLE_W-1:0]          out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         overflow,
    output logic                         timeout,
    input  logic                         clr_flags
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    sar_state_e          state_q;
    logic                go_q;
    logic                timeout_q;
    logic [TW-1:0]       timer_q;
    logic [7:0]          gap_q;
    logic [7:0]          effPeriod;
    logic                capture;
    logic                abort;
    logic                push;
    logic [SAMPLE_W-1:0] pushData;

    // A capture needs the conversion to still be enabled; an enable drop wins.
    always_comb begin
        effPeriod = (period == 8'd0) ? 8'd1 : period;
        capture   = (state_q == ST_CONV) && enable && conv_valid;
        abort     = (state_q == ST_CONV) && !enable;
    end

    // Sequencer FSM with registered go and timeout outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            go_q      <= 1'b0;
            timeout_q <= 1'b0;
            timer_q   <= '0;
            gap_q     <= '0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_q <= ST_CONV;
                        go_q    <= 1'b1;
                        timer_q <= '0;
                    end
                end
                ST_CONV: begin
                    if (!enable) begin
                        state_q <= ST_IDLE;
                        go_q    <= 1'b0;
                    end else if (conv_valid) begin
                        state_q <= ST_GAP;
                        go_q    <= 1'b0;
                        gap_q   <= 8'd1;
                    end else if (timer_q == TIMER_LAST) begin
                        state_q   <= ST_GAP;
                        go_q      <= 1'b0;
                        gap_q     <= 8'd1;
                        timeout_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_q >= effPeriod) begin
                        if (enable) begin
                            state_q <= ST_CONV;
                            go_q    <= 1'b1;
                            timer_q <= '0;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    go_q    <= 1'b0;
                end
            endcase
        end
    end

`ifdef SAR_SEQ_AVG_EN
    localparam int CW = $clog2(AVG_COUNT);
    localparam logic [CW-1:0] AVG_LAST = CW'(AVG_COUNT - 1);

    logic [AVG_SUM_W-1:0] sum_q;
    logic [AVG_SUM_W-1:0] sumNext;
    logic [CW-1:0]        avgCnt_q;

    // The sample completing a group of captures is pushed as the group mean.
    always_comb begin
        sumNext  = sum_q + AVG_SUM_W'(conv_result);
        push     = capture && (avgCnt_q == AVG_LAST);
        pushData = SAMPLE_W'(sumNext >> CW);
    end

    // Accumulator; an abort discards a partially collected group.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q    <= '0;
            avgCnt_q <= '0;
        end else if (abort) begin
            sum_q    <= '0;
            avgCnt_q <= '0;
        end else if (capture) begin
            if (avgCnt_q == AVG_LAST) begin
                sum_q    <= '0;
                avgCnt_q <= '0;
            end else begin
                sum_q    <= sumNext;
                avgCnt_q <= avgCnt_q + 1'b1;
            end
        end
    end
`else
    // Every capture goes straight into the FIFO.
    always_comb begin
        push     = capture;
        pushData = conv_result;
    end
`endif

    sar_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) uFifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (pushData),
        .pop_ready_i (out_ready),
        .clr_flags_i (clr_flags),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .count_o     (fifo_count),
        .overflow_o  (overflow)
    );

    assign go      = go_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_sar_sequencer.sv
// Self-checking bench for sar_sequencer. A bench-side SAR controller answers
// each conversion after a chosen latency (or never, to force a timeout);
// the expected go/gap timeline follows from latency and period arithmetic,
// and expected FIFO contents come from a queue model.
module tb_sar_sequencer;

    localparam int DEPTH = 4;
    localparam int TMO   = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [7:0]    period;
    logic          go;
    logic          conv_valid;
    logic [7:0]    conv_result;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic          timeout;
    logic          clr_flags;

    int            testsRun    = 0;
    int            testsFailed = 0;
    logic [7:0]    modelQ[$];
    bit            modelOvf    = 1'b0;
    int            avgSum      = 0;
    int            avgN        = 0;
    int            curGap      = 1;

    sar_sequencer #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .period      (period),
        .go          (go),
        .conv_valid  (conv_valid),
        .conv_result (conv_result),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .timeout     (timeout),
        .clr_flags   (clr_flags)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Compare every output against the expected timeline and the FIFO model.
    task automatic checkCycle(input bit expGo, input bit expTimeout);
        checkOutput("go", go, expGo);
        checkOutput("timeout", timeout, expTimeout);
        checkOutput("fifoCount", fifo_count, modelQ.size());
        checkOutput("outValid", out_valid, modelQ.size() != 0);
        if (modelQ.size() != 0) begin
            checkOutput("outData", out_data, modelQ[0]);
        end
        checkOutput("overflow", overflow, modelOvf);
    endtask

    // FIFO model: a full queue accepts a push only if the head leaves too.
    task automatic modelPush(input logic [7:0] v, input bit pop);
        bit full;
        full = (modelQ.size() == DEPTH);
        if (pop && modelQ.size() != 0) begin
            void'(modelQ.pop_front());
        end
        if (!full || pop) begin
            modelQ.push_back(v);
        end else begin
            modelOvf = 1'b1;
        end
    endtask

    task automatic modelCapture(input logic [7:0] r, input bit pop);
`ifdef SAR_SEQ_AVG_EN
        avgSum += r;
        avgN++;
        if (avgN == 4) begin
            modelPush(8'(avgSum / 4), pop);
            avgSum = 0;
            avgN   = 0;
        end else if (pop && modelQ.size() != 0) begin
            void'(modelQ.pop_front());
        end
`else
        modelPush(r, pop);
`endif
    endtask

    task automatic modelClearAvg();
        avgSum = 0;
        avgN   = 0;
    endtask

    // From idle: raise enable so the next cycle starts a conversion.
    task automatic startRun(input int p);
        period = 8'(p);
        curGap = (p == 0) ? 1 : p;
        checkCycle(1'b0, 1'b0);
        enable = 1'b1;
        tick();
    endtask

    // One conversion: answer after lat go-high cycles (lat=0 never answers),
    // then walk the gap. On the last conversion enable drops during the gap.
    task automatic applyStimulus(input int lat, input logic [7:0] res, input bit last, input bit readyAtCap);
        int dur;
        dur = (lat == 0) ? TMO : lat;
        for (int i = 0; i < dur; i++) begin
            checkCycle(1'b1, 1'b0);
            conv_valid  = (lat != 0) && (i == lat - 1);
            conv_result = conv_valid ? res : 8'($urandom);
            out_ready   = conv_valid && readyAtCap;
            if (conv_valid) begin
                modelCapture(res, readyAtCap);
            end
            tick();
        end
        out_ready = 1'b0;
        for (int j = 0; j < curGap; j++) begin
            checkCycle(1'b0, (lat == 0) && (j == 0));
            conv_valid  = 1'($urandom);
            conv_result = 8'($urandom);
            if (last && j == 0) begin
                enable = 1'b0;
            end
            tick();
        end
        conv_valid = 1'b0;
        if (last) begin
            checkCycle(1'b0, 1'b0);
        end
    endtask

    // Pop everything with out_ready held high, checking each head.
    task automatic drain();
        out_ready = 1'b1;
        for (int n = 0; n < DEPTH + 1; n++) begin
            checkCycle(1'b0, 1'b0);
            if (modelQ.size() != 0) begin
                void'(modelQ.pop_front());
            end
            tick();
        end
        out_ready = 1'b0;
        checkCycle(1'b0, 1'b0);
    endtask

    initial begin
        rst_n       = 1'b0;
        enable      = 1'b0;
        period      = 8'd0;
        conv_valid  = 1'b0;
        conv_result = 8'd0;
        out_ready   = 1'b0;
        clr_flags   = 1'b0;
        #12;
        checkOutput("resetGo", go, 1'b0);
        checkOutput("resetCount", fifo_count, 0);
        checkOutput("resetOutData", out_data, 8'h00);
        checkOutput("resetOverflow", overflow, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Basic run: answer 0xA5 after 10 go-high cycles, 3-cycle gap.
        startRun(3);
        applyStimulus(10, 8'hA5, 1'b0, 1'b0);
        applyStimulus(4, 8'h5A, 1'b1, 1'b0);
        drain();

        // Timeout: controller never answers, then a normal conversion.
        startRun(2);
        applyStimulus(0, 8'h00, 1'b0, 1'b0);
        applyStimulus(5, 8'h3C, 1'b1, 1'b0);
        drain();

        // Randomized runs: random period, latencies and occasional timeouts.
        for (int run = 0; run < 6; run++) begin
            int nConv;
            nConv = int'($urandom_range(1, 4));
            startRun(int'($urandom_range(0, 4)));
            for (int c = 0; c < nConv; c++) begin
                int lat;
                lat = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 12));
                applyStimulus(lat, 8'($urandom), c == nConv - 1, 1'b0);
            end
            drain();
        end

        // Abort: enable drops in CONV while conv_valid is high.
        period = 8'd1;
        enable = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            checkCycle(1'b1, 1'b0);
            tick();
        end
        checkCycle(1'b1, 1'b0);
        enable      = 1'b0;
        conv_valid  = 1'b1;
        conv_result = 8'hEE;
        modelClearAvg();
        tick();
        conv_valid = 1'b0;
        checkCycle(1'b0, 1'b0);
        tick();
        checkCycle(1'b0, 1'b0);

`ifndef SAR_SEQ_AVG_EN
        // Overflow: five captures with no consumer, then clear the flag.
        startRun(1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(2, 8'(i + 1), i == 4, 1'b0);
        end
        checkOutput("ovfCount", fifo_count, 4);
        checkOutput("ovfFlag", overflow, 1'b1);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        modelOvf  = 1'b0;
        checkCycle(1'b0, 1'b0);

        // Full FIFO with a pop in the capture cycle: accepted, no overflow.
        startRun(1);
        applyStimulus(3, 8'h77, 1'b1, 1'b1);
        checkOutput("fullPushPopCount", fifo_count, 4);
        checkOutput("fullPushPopHead", out_data, 8'h02);
        drain();
`else
        // Averaging: four captures produce exactly one pushed mean.
        startRun(1);
        applyStimulus(2, 8'h10, 1'b0, 1'b0);
        applyStimulus(2, 8'h20, 1'b0, 1'b0);
        applyStimulus(2, 8'h30, 1'b0, 1'b0);
        applyStimulus(2, 8'h41, 1'b1, 1'b0);
        checkOutput("avgCount", fifo_count, 1);
        checkOutput("avgValue", out_data, 8'h28);
        drain();
`endif

        // Reset pulse in the middle of a conversion with data in the FIFO.
        startRun(2);
        applyStimulus(3, 8'h99, 1'b0, 1'b0);
        checkCycle(1'b1, 1'b0);
        tick();
        checkCycle(1'b1, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("midResetGo", go, 1'b0);
        checkOutput("midResetCount", fifo_count, 0);
        checkOutput("midResetValid", out_valid, 1'b0);
        checkOutput("midResetOutData", out_data, 8'h00);
        checkOutput("midResetOverflow", overflow, 1'b0);
        checkOutput("midResetTimeout", timeout, 1'b0);
        enable = 1'b0;
        modelQ.delete();
        modelOvf = 1'b0;
        modelClearAvg();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        checkCycle(1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
